mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified memory port between instruction fetch (IF) and data
//  access (D). It grants one requester at a time, holds address/write data stable
//  until the memory acks, and returns read data to the granted requester.
//  It drives the 2-bit select of the 3-input address mux in front of the memory
//  port. Sits between the fetch/LSU stages and the memory interface.
// PARAMETERS
//  DATA_WIDTH  32   width of read/write data
//  ADDR_WIDTH  32   width of addresses
//  TIMEOUT     255  max cycles waiting for mem_ack before abort (>=1)
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           asynchronous reset, active-high
//  if_req     in   1           fetch request; held high until if_ready
//  if_addr    in   ADDR_WIDTH  fetch address
//  if_ready   out  1           1-cycle pulse: fetch done, if_rdata valid
//  if_rdata   out  DATA_WIDTH  fetched word (registered)
//  d_req      in   1           data request; held high until d_ready
//  d_we       in   1           1 = store, 0 = load
//  d_addr     in   ADDR_WIDTH  data address
//  d_wdata    in   DATA_WIDTH  store data
//  d_ready    out  1           1-cycle pulse: data access done, d_rdata valid
//  d_rdata    out  DATA_WIDTH  load data (registered; 0 for stores)
//  mem_req    out  1           memory request, held until mem_ack
//  mem_we     out  1           memory write enable
//  mem_addr   out  ADDR_WIDTH  memory address (registered at grant)
//  mem_wdata  out  DATA_WIDTH  memory write data (registered at grant)
//  mem_ack    in   1           memory done; mem_rdata valid this cycle
//  mem_rdata  in   DATA_WIDTH  memory read data
//  addr_sel   out  2           mux select: 00 = IF, 01 = D, 11 = idle (mux outputs 0)
//  err_timeout out 1           pulses together with ready when an access aborts
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE; every output 0 except addr_sel = 11;
//    last_grant = D (IF wins the first tie); wait counter = 0.
//    A reset mid-access drops mem_req immediately; no ready pulse is issued.
//  - FSM states: IDLE, GNT_IF, GNT_D, RESP. All outputs are registered.
//  - IDLE: a pending requester is eligible if its req = 1.
//    - Neither eligible: stay in IDLE.
//    - One eligible: grant it.
//    - Both eligible: grant the requester not in last_grant.
//    - On grant, the next cycle shows: state GNT_x, mem_req = 1, and
//      mem_addr/mem_we/mem_wdata latched from the requester (IF: we = 0, wdata = 0).
//      addr_sel = 00 or 01 accordingly, and last_grant updates.
//  - GNT_x: outputs are held stable and the wait counter increments each cycle.
//    - mem_ack = 1: capture mem_rdata (0 if write); go to RESP; mem_req = 0;
//      addr_sel = 11.
//    - Counter reaches TIMEOUT with no ack: go to RESP with rdata = 0 and
//      err_timeout = 1. A late mem_ack after abort is ignored.
//  - RESP (exactly 1 cycle): the granted requester's ready = 1 with registered rdata.
//    Next state is always IDLE. The counter clears.
//  - Requester contract: it holds req and its operands until it sees ready. It may
//    drop req or present a new access in the cycle after ready. Because RESP
//    returns to IDLE, stale req during RESP is never re-granted.
//  - Latency: req seen in IDLE at cycle 0 -> mem_req at cycle 1 -> ack at cycle k
//    (k >= 1) -> ready at cycle k+1 -> IDLE at cycle k+2. The minimum is a 3-cycle
//    turnaround.
//  - if_ready and d_ready are never high together. mem_req is never high in IDLE
//    or RESP.
//  - Changes to the ungranted requester's inputs during a grant have no effect.
// TESTING
//  1. Reset, if_req=1, if_addr=0x100, mem_ack at cycle 1, mem_rdata=0xDEADBEEF
//     -> mem_addr=0x100, addr_sel=00 in cycle 1; if_ready=1, if_rdata=0xDEADBEEF
//     in cycle 2.
//  2. Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0x55, ack after 3 cycles
//     -> mem_we=1, mem_wdata=0x55 stable for 3 cycles, addr_sel=01; d_ready pulses,
//     d_rdata=0.
//  3. if_req and d_req both held high for 4 accesses -> grants IF, D, IF, D;
//     neither requester is starved.
//  4. TIMEOUT=4, mem_ack never asserted -> mem_req high for 4 cycles, then d_ready=1
//     and err_timeout=1 together, d_rdata=0; a late ack is ignored.
//  5. rst pulsed while in GNT_D -> mem_req=0 and addr_sel=11 at once; no d_ready;
//     first grant after reset goes to IF on a tie.
//  6. Back-to-back fetches at 0x0 and 0x4 with zero-wait ack -> if_ready pulses
//     3 cycles apart; mem_req stays low in RESP/IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter for the shared memory port between instruction fetch and data access.
// One access is in flight at a time. Ties alternate between IF and D, and a stuck access is aborted after TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            addr_sel,
    output logic                  err_timeout
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] SEL_IF   = 2'b00;
    localparam logic [1:0] SEL_D    = 2'b01;
    localparam logic [1:0] SEL_IDLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        GNT_IF,
        GNT_D,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             last_d;
    logic             pick_d;
    logic             access_done;

    // D wins only if IF is not asking, or if IF was served last.
    always_comb begin
        pick_d      = d_req && (!if_req || !last_d);
        access_done = mem_ack || (wait_cnt == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            last_d      <= 1'b1;
            if_ready    <= 1'b0;
            if_rdata    <= '0;
            d_ready     <= 1'b0;
            d_rdata     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            addr_sel    <= SEL_IDLE;
            err_timeout <= 1'b0;
        end else begin
            if_ready    <= 1'b0;
            d_ready     <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        mem_req <= 1'b1;
                        last_d  <= pick_d;
                        if (pick_d) begin
                            state     <= GNT_D;
                            addr_sel  <= SEL_D;
                            mem_addr  <= d_addr;
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                        end else begin
                            state     <= GNT_IF;
                            addr_sel  <= SEL_IF;
                            mem_addr  <= if_addr;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                        end
                    end
                end
                GNT_IF, GNT_D: begin
                    // An ack that arrives in the last allowed cycle still counts as success.
                    if (access_done) begin
                        state       <= RESP;
                        mem_req     <= 1'b0;
                        mem_we      <= 1'b0;
                        addr_sel    <= SEL_IDLE;
                        err_timeout <= !mem_ack;
                        if (state == GNT_D) begin
                            d_ready <= 1'b1;
                            d_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_ack ? mem_rdata : '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_ready_exclusive: assert property (@(posedge clk) disable iff (rst) !(if_ready && d_ready));
    a_no_req_when_idle: assert property (@(posedge clk) disable iff (rst)
        ((state == IDLE) || (state == RESP)) |-> !mem_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected responses, a negedge monitor retires them.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    addr_sel;
    logic          err_timeout;

    typedef struct packed {
        logic          is_d;
        logic [DW-1:0] rdata;
        logic          err;
    } resp_t;

    resp_t         exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            ack_latency = 1;
    logic [DW-1:0] rdata_val = '0;
    int            late_ack_req = 0;
    int            late_ack_done = 0;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .addr_sel(addr_sel), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: acks after ack_latency cycles of mem_req (0 = never), plus on-demand stray acks.
    initial begin : responder
        int req_cnt;
        req_cnt   = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            tick();
            if (late_ack_req != late_ack_done) begin
                late_ack_done = late_ack_req;
                mem_ack   = 1'b1;
                mem_rdata = 32'hBADB_AD00;
            end else if (mem_req && ack_latency != 0) begin
                req_cnt++;
                mem_ack   = (req_cnt == ack_latency);
                mem_rdata = (req_cnt == ack_latency) ? rdata_val : '0;
            end else begin
                req_cnt   = 0;
                mem_ack   = 1'b0;
                mem_rdata = '0;
            end
        end
    end

    initial begin : monitor
        resp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (if_ready || d_ready)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_ready: got if_ready=%0b d_ready=%0b, expected none",
                             if_ready, d_ready);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("ready_port", {if_ready, d_ready}, e.is_d ? 2'b01 : 2'b10);
                    checkOutput("ready_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
                    checkOutput("ready_err", err_timeout, e.err);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single-requester access; lat = 0 means the memory never acks.
    task automatic applyStimulus(input bit is_d, input bit we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input int lat,
                                 input logic [DW-1:0] rdv, input int exp_wait,
                                 input bit drop, output int ready_cyc);
        resp_t         e;
        int            n;
        int            req_cycles;
        bit            got;
        logic [DW-1:0] exp_wd;
        logic [1:0]    exp_sel;
        ack_latency = lat;
        rdata_val   = rdv;
        e.is_d  = is_d;
        e.err   = (lat == 0);
        e.rdata = (lat == 0 || (is_d && we)) ? '0 : rdv;
        exp_q.push_back(e);
        exp_wd  = is_d ? wdata : '0;
        exp_sel = is_d ? 2'b01 : 2'b00;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_req && n < 8);
        checkOutput("grant_wait", n, exp_wait);
        checkOutput("grant_addr", mem_addr, addr);
        checkOutput("grant_we", mem_we, is_d & we);
        checkOutput("grant_wdata", mem_wdata, exp_wd);
        checkOutput("grant_sel", addr_sel, exp_sel);
        req_cycles = 1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (is_d ? d_ready : if_ready) begin
                got = 1;
                break;
            end
            checkOutput("hold_req", mem_req, 1'b1);
            checkOutput("hold_addr", mem_addr, addr);
            checkOutput("hold_wdata", mem_wdata, exp_wd);
            req_cycles++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_seen: got no ready, expected ready within 20 cycles");
        end
        checkOutput("req_cycles", req_cycles, (lat == 0) ? TO : lat);
        checkOutput("resp_mem_req", mem_req, 1'b0);
        checkOutput("resp_sel", addr_sel, 2'b11);
        ready_cyc = cyc;
        if (drop) begin
            if (is_d) d_req = 1'b0;
            else if_req = 1'b0;
        end
    endtask

    // Both requesters held high; grants must alternate starting with IF.
    task automatic fairRun(input int count);
        resp_t e;
        int    n;
        bit    port;
        bit    got;
        if_addr = 32'h300; d_addr = 32'h400; d_we = 1'b0; d_wdata = 32'h0;
        ack_latency = 1;
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < count; i++) begin
            port = i[0];
            rdata_val = 32'hA000_0000 + i;
            e.is_d = port; e.rdata = rdata_val; e.err = 1'b0;
            exp_q.push_back(e);
            n = 0;
            do begin
                tick();
                n++;
            end while (!mem_req && n < 8);
            checkOutput("fair_wait", n, (i == 0) ? 1 : 2);
            checkOutput("fair_sel", addr_sel, port ? 2'b01 : 2'b00);
            checkOutput("fair_addr", mem_addr, port ? d_addr : if_addr);
            got = 0;
            for (int j = 0; j < 20; j++) begin
                tick();
                if (port ? d_ready : if_ready) begin
                    got = 1;
                    break;
                end
            end
            if (!got) begin
                checks++;
                errors++;
                $display("[TB] FAIL fair_ready: got no ready, expected ready for access %0d", i);
            end
            if (port) d_addr = d_addr + 4;
            else if_addr = if_addr + 4;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    initial begin : stimulus
        int c1;
        int c2;
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) tick();
        checkOutput("rst_mem_req", mem_req, 1'b0);
        checkOutput("rst_sel", addr_sel, 2'b11);
        checkOutput("rst_ready", {if_ready, d_ready, err_timeout}, 3'b000);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;
        tick();

        $display("[TB] fetch with single-cycle ack");
        applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 1, 32'hDEAD_BEEF, 1, 1'b1, c1);
        tick();

        $display("[TB] store with 3-cycle ack");
        applyStimulus(1'b1, 1'b1, 32'h2000, 32'h55, 3, 32'h7777_7777, 1, 1'b1, c1);
        tick();

        $display("[TB] alternating grants under contention");
        fairRun(4);
        tick();

        $display("[TB] timeout abort and late ack");
        applyStimulus(1'b1, 1'b0, 32'h3000, 32'h0, 0, 32'h0BAD, 1, 1'b1, c1);
        late_ack_req++;
        repeat (3) begin
            tick();
            checkOutput("late_ack_mem_req", mem_req, 1'b0);
        end

        $display("[TB] back-to-back fetches");
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1, 32'h1111_1111, 1, 1'b0, c1);
        applyStimulus(1'b0, 1'b0, 32'h4, 32'h0, 1, 32'h2222_2222, 2, 1'b1, c2);
        checkOutput("b2b_spacing", c2 - c1, 3);
        tick();

        $display("[TB] reset during data grant");
        ack_latency = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
        tick();
        checkOutput("pre_rst_sel", addr_sel, 2'b01);
        checkOutput("pre_rst_req", mem_req, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        checkOutput("async_rst_req", mem_req, 1'b0);
        checkOutput("async_rst_sel", addr_sel, 2'b11);
        checkOutput("async_rst_ready", d_ready, 1'b0);
        d_req = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checkOutput("post_rst_req", mem_req, 1'b0);
        fairRun(2);

        repeat (3) tick();
        checkOutput("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
